// File: rtl/scan_seq16_pkg.sv
// Shared types and constants for the 16-line decoder scan sequencer.
package scan_seq16_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    localparam logic        MODE_CONT   = 1'b0;
    localparam logic        MODE_SWEEP  = 1'b1;
    localparam logic [15:0] ALL_SKIPPED = 16'hFFFF;

endpackage

// File: rtl/scan_seq16_if.sv
// Control/status bundle between a scan requester and the scan_seq16 sequencer.
interface scan_seq16_if #(parameter int DWELL_W = 8);

    logic               Start;
    logic               Stop;
    logic               Mode;
    logic [DWELL_W-1:0] Dwell;
    logic [15:0]        Skip;
    logic [3:0]         W;
    logic               En;
    logic               Busy;
    logic               Done;
    logic               Wrap;

    modport master (
        output Start, Stop, Mode, Dwell, Skip,
        input  W, En, Busy, Done, Wrap
    );

    modport slave (
        input  Start, Stop, Mode, Dwell, Skip,
        output W, En, Busy, Done, Wrap
    );

endinterface

// File: rtl/next_unmasked16.sv
// Skip-mask search: next unmasked line above the current one, and the lowest
// unmasked line overall.
module next_unmasked16
    import scan_seq16_pkg::*;
(
    input  logic [3:0]  cur_i,
    input  logic [15:0] skip_i,
    output logic [3:0]  next_o,
    output logic        found_above_o,
    output logic [3:0]  lowest_o,
    output logic        any_unmasked_o
);

    always_comb begin
        next_o         = 4'd0;
        found_above_o  = 1'b0;
        lowest_o       = 4'd0;
        any_unmasked_o = (skip_i != ALL_SKIPPED);
        // Scanning downwards leaves the lowest qualifying index as the winner.
        for (int i = 15; i >= 0; i--) begin
            if (!skip_i[i]) begin
                lowest_o = 4'(i);
                if (i > int'(cur_i)) begin
                    next_o        = 4'(i);
                    found_above_o = 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/scan_seq16.sv
// Scan sequencer driving the select code and enable of a 4-to-16 active-low
// decoder, with per-line dwell, skip mask, single-sweep and continuous modes.
module scan_seq16
    import scan_seq16_pkg::*;
#(
    parameter int DWELL_W = 8
) (
    input  logic        Clock,
    input  logic        Resetn,
    scan_seq16_if.slave bus
);

    state_t             state_q, state_d;
    logic               mode_q, mode_d;
    logic [DWELL_W-1:0] dwell_q, dwell_d;
    logic [15:0]        skip_q, skip_d;
    logic [DWELL_W-1:0] cnt_q, cnt_d;
    logic [3:0]         w_q, w_d;
    logic               en_q, en_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;
    logic               wrap_q, wrap_d;

    logic [15:0] mask_sel;
    logic [3:0]  next_idx;
    logic        found_above;
    logic [3:0]  lowest_idx;
    logic        any_unmasked;

    // In IDLE the live mask decides the first line; in RUN only the latched one counts.
    assign mask_sel = (state_q == IDLE) ? bus.Skip : skip_q;

    next_unmasked16 u_search (
        .cur_i          (w_q),
        .skip_i         (mask_sel),
        .next_o         (next_idx),
        .found_above_o  (found_above),
        .lowest_o       (lowest_idx),
        .any_unmasked_o (any_unmasked)
    );

    always_comb begin
        state_d = state_q;
        mode_d  = mode_q;
        dwell_d = dwell_q;
        skip_d  = skip_q;
        cnt_d   = cnt_q;
        w_d     = w_q;
        en_d    = en_q;
        busy_d  = busy_q;
        done_d  = 1'b0;
        wrap_d  = 1'b0;

        unique case (state_q)
            IDLE: begin
                w_d    = 4'd0;
                en_d   = 1'b0;
                busy_d = 1'b0;
                if (bus.Start && !bus.Stop) begin
                    mode_d  = bus.Mode;
                    dwell_d = bus.Dwell;
                    skip_d  = bus.Skip;
                    if (any_unmasked) begin
                        state_d = RUN;
                        w_d     = lowest_idx;
                        en_d    = 1'b1;
                        busy_d  = 1'b1;
                        cnt_d   = bus.Dwell;
                    end else begin
                        done_d = 1'b1;
                    end
                end
            end
            RUN: begin
                if (bus.Stop) begin
                    state_d = IDLE;
                    w_d     = 4'd0;
                    en_d    = 1'b0;
                    busy_d  = 1'b0;
                end else if (cnt_q != '0) begin
                    cnt_d = cnt_q - 1'b1;
                end else if (found_above) begin
                    w_d   = next_idx;
                    cnt_d = dwell_q;
                end else if (mode_q == MODE_SWEEP) begin
                    state_d = IDLE;
                    w_d     = 4'd0;
                    en_d    = 1'b0;
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                end else begin
                    w_d    = lowest_idx;
                    cnt_d  = dwell_q;
                    wrap_d = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge Clock or negedge Resetn) begin
        if (!Resetn) begin
            state_q <= IDLE;
            mode_q  <= MODE_CONT;
            dwell_q <= '0;
            skip_q  <= '0;
            cnt_q   <= '0;
            w_q     <= 4'd0;
            en_q    <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            wrap_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            mode_q  <= mode_d;
            dwell_q <= dwell_d;
            skip_q  <= skip_d;
            cnt_q   <= cnt_d;
            w_q     <= w_d;
            en_q    <= en_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            wrap_q  <= wrap_d;
        end
    end

    assign bus.W    = w_q;
    assign bus.En   = en_q;
    assign bus.Busy = busy_q;
    assign bus.Done = done_q;
    assign bus.Wrap = wrap_q;

endmodule

// File: tb/tb_scan_seq16.sv
// Bench for scan_seq16: line-list model checked every cycle plus directed literal checks.
module tb_scan_seq16;
    import scan_seq16_pkg::*;

    localparam int DW = 8;

    logic Clock  = 1'b0;
    logic Resetn = 1'b1;

    scan_seq16_if #(.DWELL_W(DW)) bus();

    scan_seq16 #(.DWELL_W(DW)) dut (
        .Clock  (Clock),
        .Resetn (Resetn),
        .bus    (bus)
    );

    always #5 Clock = ~Clock;

    int errors = 0;
    int checks = 0;

    // Model: the list of lines to visit, a position in it and cycles spent on the current line.
    bit m_run;
    bit m_mode;
    int m_dwell;
    int lines[$];
    int pos;
    int held;
    int exp_w, exp_en, exp_busy, exp_done, exp_wrap;

    task automatic check(input string name, input int act, input int expv);
        checks++;
        if (act != expv) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, expv, $time);
        end
    endtask

    task automatic model_reset();
        m_run    = 1'b0;
        exp_w    = 0;
        exp_en   = 0;
        exp_busy = 0;
        exp_done = 0;
        exp_wrap = 0;
    endtask

    task automatic model_step(input bit st, input bit sp);
        exp_done = 0;
        exp_wrap = 0;
        if (!m_run) begin
            if (st && !sp) begin
                lines.delete();
                for (int i = 0; i < 16; i++)
                    if (!bus.Skip[i]) lines.push_back(i);
                m_mode  = bus.Mode;
                m_dwell = int'(bus.Dwell);
                if (lines.size() == 0) begin
                    exp_done = 1;
                end else begin
                    m_run    = 1'b1;
                    pos      = 0;
                    held     = 0;
                    exp_w    = lines[0];
                    exp_en   = 1;
                    exp_busy = 1;
                end
            end
        end else if (sp) begin
            m_run    = 1'b0;
            exp_w    = 0;
            exp_en   = 0;
            exp_busy = 0;
        end else begin
            held++;
            if (held > m_dwell) begin
                held = 0;
                pos++;
                if (pos == lines.size()) begin
                    if (m_mode == MODE_SWEEP) begin
                        m_run    = 1'b0;
                        exp_w    = 0;
                        exp_en   = 0;
                        exp_busy = 0;
                        exp_done = 1;
                    end else begin
                        pos      = 0;
                        exp_wrap = 1;
                        exp_w    = lines[0];
                    end
                end else begin
                    exp_w = lines[pos];
                end
            end
        end
    endtask

    always @(negedge Clock) begin
        check("cmp_W",    int'(bus.W),    exp_w);
        check("cmp_En",   int'(bus.En),   exp_en);
        check("cmp_Busy", int'(bus.Busy), exp_busy);
        check("cmp_Done", int'(bus.Done), exp_done);
        check("cmp_Wrap", int'(bus.Wrap), exp_wrap);
    end

    task automatic cyc(input bit st = 1'b0, input bit sp = 1'b0);
        bus.Start = st;
        bus.Stop  = sp;
        @(posedge Clock);
        #1;
        model_step(st, sp);
        bus.Start = 1'b0;
        bus.Stop  = 1'b0;
    endtask

    task automatic do_reset();
        #1;
        Resetn = 1'b0;
        #1;
        check("rst_W",    int'(bus.W),    0);
        check("rst_En",   int'(bus.En),   0);
        check("rst_Busy", int'(bus.Busy), 0);
        check("rst_Done", int'(bus.Done), 0);
        check("rst_Wrap", int'(bus.Wrap), 0);
        model_reset();
        repeat (2) @(posedge Clock);
        #1;
        Resetn = 1'b1;
    endtask

    task automatic setup(input bit mode, input int dwell, input logic [15:0] skip);
        bus.Mode  = mode;
        bus.Dwell = DW'(dwell);
        bus.Skip  = skip;
    endtask

    initial begin
        int cnt0, cnt15, cntmid, dones, wraps, first_wrap, done_at;
        bit hit;

        model_reset();
        bus.Start = 1'b0;
        bus.Stop  = 1'b0;
        setup(MODE_SWEEP, 0, 16'h0000);
        #2;
        do_reset();
        cyc();

        // Sweep of all 16 lines, one cycle each.
        setup(MODE_SWEEP, 0, 16'h0000);
        cyc(1'b1);
        check("sweep_first_W", int'(bus.W), 0);
        check("sweep_first_En", int'(bus.En), 1);
        for (int i = 1; i < 16; i++) begin
            cyc();
            check("sweep_W", int'(bus.W), i);
        end
        cyc();
        check("sweep_end_En", int'(bus.En), 0);
        check("sweep_end_W", int'(bus.W), 0);
        check("sweep_end_Done", int'(bus.Done), 1);
        cyc();
        check("sweep_done_once", int'(bus.Done), 0);

        // Skip mask 7FFE with dwell 2: lines 0 and 15 only, three cycles each.
        setup(MODE_SWEEP, 2, 16'h7FFE);
        cnt0 = 0; cnt15 = 0; cntmid = 0; dones = 0;
        cyc(1'b1);
        for (int n = 0; n < 9; n++) begin
            if (bus.En && bus.W == 4'd0) cnt0++;
            if (bus.En && bus.W == 4'd15) cnt15++;
            if (bus.En && bus.W != 4'd0 && bus.W != 4'd15) cntmid++;
            if (bus.Done) dones++;
            cyc();
        end
        check("skip_w0_cycles", cnt0, 3);
        check("skip_w15_cycles", cnt15, 3);
        check("skip_mid_lines", cntmid, 0);
        check("skip_done_pulses", dones, 1);

        // Continuous over lines 0..3, dwell 1: wrap on each returning line 0.
        setup(MODE_CONT, 1, 16'hFFF0);
        wraps = 0; dones = 0; first_wrap = -1;
        cyc(1'b1);
        for (int n = 0; n < 20; n++) begin
            if (bus.Wrap) begin
                wraps++;
                if (first_wrap < 0) first_wrap = n;
            end
            if (bus.Done) dones++;
            if (n == 5) check("cont_w_at5", int'(bus.W), 2);
            cyc();
        end
        check("cont_wraps", wraps, 2);
        check("cont_first_wrap", first_wrap, 8);
        check("cont_no_done", dones, 0);
        cyc(1'b0, 1'b1);
        check("cont_stop_busy", int'(bus.Busy), 0);

        // Stop while dwelling on line 7.
        setup(MODE_SWEEP, 3, 16'h0000);
        hit = 1'b0;
        cyc(1'b1);
        for (int n = 0; n < 40 && !hit; n++) begin
            if (bus.W == 4'd7) hit = 1'b1;
            else cyc();
        end
        check("reach_w7", int'(hit), 1);
        cyc();
        cyc(1'b0, 1'b1);
        check("stop_En", int'(bus.En), 0);
        check("stop_W", int'(bus.W), 0);
        check("stop_Busy", int'(bus.Busy), 0);
        check("stop_Done", int'(bus.Done), 0);
        cyc();
        check("stop_no_late_done", int'(bus.Done), 0);

        // Start together with Stop in IDLE, and Stop alone in IDLE.
        cyc(1'b1, 1'b1);
        check("startstop_Busy", int'(bus.Busy), 0);
        check("startstop_En", int'(bus.En), 0);
        cyc(1'b0, 1'b1);
        check("idle_stop_Busy", int'(bus.Busy), 0);

        // Start during RUN with new parameters must not disturb the scan.
        setup(MODE_SWEEP, 1, 16'hFFFC);
        cyc(1'b1);
        setup(MODE_CONT, 5, 16'h0000);
        done_at = -1;
        for (int n = 1; n < 9; n++) begin
            cyc(n == 1);
            if (bus.Done && done_at < 0) done_at = n;
        end
        check("restart_done_at", done_at, 4);

        // All lines skipped, both modes.
        setup(MODE_CONT, 0, ALL_SKIPPED);
        cyc(1'b1);
        check("allskip_c_Done", int'(bus.Done), 1);
        check("allskip_c_En", int'(bus.En), 0);
        check("allskip_c_Busy", int'(bus.Busy), 0);
        cyc();
        check("allskip_c_once", int'(bus.Done), 0);
        setup(MODE_SWEEP, 4, ALL_SKIPPED);
        cyc(1'b1);
        check("allskip_s_Done", int'(bus.Done), 1);
        check("allskip_s_En", int'(bus.En), 0);
        cyc();
        check("allskip_s_once", int'(bus.Done), 0);

        // Asynchronous reset mid-scan, then a fresh start from line 8.
        setup(MODE_CONT, 5, 16'h0000);
        cyc(1'b1);
        repeat (8) cyc();
        do_reset();
        cyc();
        setup(MODE_SWEEP, 0, 16'h00FF);
        cyc(1'b1);
        check("post_reset_first_W", int'(bus.W), 8);
        repeat (10) cyc();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
